// File: rtl/controle_tiros.sv
// Shot-resolution and board-storage controller: per-player occupancy maps, shot histories,
// life counters, and arbitration between the placement and shot requesters.
module controle_tiros #(
  parameter int unsigned BOARD_DIM = 10,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned VIDA_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               place_valid,
  input  logic               place_player,
  input  logic [COORD_W-1:0] place_x,
  input  logic [COORD_W-1:0] place_y,
  output logic               place_ready,
  output logic               place_err,
  input  logic               shot_valid,
  input  logic               shot_player,
  input  logic [COORD_W-1:0] shot_x,
  input  logic [COORD_W-1:0] shot_y,
  output logic               shot_ready,
  output logic               res_valid,
  output logic               acertou_tiro,
  output logic               repetido,
  output logic [VIDA_W-1:0]  qtd_P1,
  output logic [VIDA_W-1:0]  qtd_P2,
  output logic               fim_jogo
);

  localparam int unsigned Cells = BOARD_DIM * BOARD_DIM;
  localparam int unsigned IdxW  = (Cells > 1) ? $clog2(Cells) : 1;
  localparam int unsigned MulW  = IdxW + COORD_W;
  localparam logic [COORD_W:0]  DimC    = (COORD_W + 1)'(BOARD_DIM);
  localparam logic [VIDA_W-1:0] VidaMax = '1;

  typedef enum logic [1:0] {StIdle, StLookup, StRespond} state_e;

  state_e state_q, state_d;

  logic [1:0][Cells-1:0]  occ_q, hist_q;
  logic [1:0][VIDA_W-1:0] qtd_q;
  logic                   armed_q, fim_q;
  logic                   pl_q;
  logic [COORD_W-1:0]     x_q, y_q;
  logic                   rng_q, occ_bit_q, hist_bit_q;
  logic                   res_valid_q, acertou_q, repetido_q, place_err_q;

  logic            place_fire, shot_fire;
  logic            place_rng, shot_rng;
  logic [IdxW-1:0] place_idx, shot_idx;
  logic            tgt;

  function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return ({1'b0, x} < DimC) && ({1'b0, y} < DimC);
  endfunction

  function automatic logic [IdxW-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y);
    logic [MulW-1:0] p;
    p = MulW'(y) * MulW'(BOARD_DIM) + MulW'(x);
    return p[IdxW-1:0];
  endfunction

  assign place_rng = in_range(place_x, place_y);
  assign place_idx = cell_idx(place_x, place_y);
  assign shot_rng  = in_range(x_q, y_q);
  assign shot_idx  = cell_idx(x_q, y_q);
  // The shooter fires at the opponent's board.
  assign tgt       = ~pl_q;

  assign place_fire = place_valid & place_ready;
  assign shot_fire  = shot_valid & shot_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (shot_fire) state_d = StLookup;
      StLookup:  if (enable) state_d = StRespond;
      StRespond: if (enable) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    place_ready = enable & (state_q == StIdle) & ~armed_q;
    shot_ready  = enable & (state_q == StIdle) & ~fim_q & ~place_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q       <= '0;
      hist_q      <= '0;
      qtd_q       <= '0;
      armed_q     <= 1'b0;
      fim_q       <= 1'b0;
      pl_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      rng_q       <= 1'b0;
      occ_bit_q   <= 1'b0;
      hist_bit_q  <= 1'b0;
      res_valid_q <= 1'b0;
      acertou_q   <= 1'b0;
      repetido_q  <= 1'b0;
      place_err_q <= 1'b0;
    end else if (clear) begin
      occ_q       <= '0;
      hist_q      <= '0;
      qtd_q       <= '0;
      armed_q     <= 1'b0;
      fim_q       <= 1'b0;
      pl_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      rng_q       <= 1'b0;
      occ_bit_q   <= 1'b0;
      hist_bit_q  <= 1'b0;
      res_valid_q <= 1'b0;
      acertou_q   <= 1'b0;
      repetido_q  <= 1'b0;
      place_err_q <= 1'b0;
    end else begin
      // Result and error outputs are single-cycle pulses.
      res_valid_q <= 1'b0;
      acertou_q   <= 1'b0;
      repetido_q  <= 1'b0;
      place_err_q <= 1'b0;
      if (enable) begin
        fim_q <= armed_q & ((qtd_q[0] == '0) | (qtd_q[1] == '0));
        if (place_fire) begin
          if (!place_rng || occ_q[place_player][place_idx] || qtd_q[place_player] == VidaMax) begin
            place_err_q <= 1'b1;
          end else begin
            occ_q[place_player][place_idx] <= 1'b1;
            qtd_q[place_player]            <= qtd_q[place_player] + 1'b1;
          end
        end
        if (shot_fire) begin
          pl_q    <= shot_player;
          x_q     <= shot_x;
          y_q     <= shot_y;
          armed_q <= 1'b1;
        end
        if (state_q == StLookup) begin
          rng_q      <= shot_rng;
          occ_bit_q  <= shot_rng & occ_q[tgt][shot_idx];
          hist_bit_q <= shot_rng & hist_q[tgt][shot_idx];
        end
        if (state_q == StRespond) begin
          res_valid_q <= 1'b1;
          if (!rng_q || hist_bit_q) begin
            repetido_q <= 1'b1;
          end else begin
            hist_q[tgt][shot_idx] <= 1'b1;
            acertou_q             <= occ_bit_q;
            if (occ_bit_q) begin
              occ_q[tgt][shot_idx] <= 1'b0;
              qtd_q[tgt]           <= qtd_q[tgt] - 1'b1;
            end
          end
        end
      end
    end
  end

  assign place_err    = place_err_q;
  assign res_valid    = res_valid_q;
  assign acertou_tiro = acertou_q;
  assign repetido     = repetido_q;
  assign qtd_P1       = qtd_q[0];
  assign qtd_P2       = qtd_q[1];
  assign fim_jogo     = fim_q;

endmodule
